// File: rtl/bpu_update_sched_pkg.sv
// Shared types for the BPU update scheduler: update record, branch-type
// encodings, scheduler states and the default table index width.
package bpu_update_sched_pkg;

    // Index width of the largest BPU table (BTB/BHT/LPHT); sets clear-walk length.
    localparam int unsigned BPU_TBL_IDX_W = 10;

    // One-hot branch type encodings.
    typedef logic [3:0] br_type_t;
    localparam br_type_t BR_TYPE_CALL        = 4'b0001;
    localparam br_type_t BR_TYPE_RETURN      = 4'b0010;
    localparam br_type_t BR_TYPE_ABSOLUTE    = 4'b0100;
    localparam br_type_t BR_TYPE_PC_RELATIVE = 4'b1000;

    // Resolved-branch feedback record; pc and br_target are word addresses.
    typedef struct packed {
        logic        flush;
        logic        br_taken;
        logic [29:0] pc;
        logic [29:0] br_target;
        br_type_t    br_type;
        logic        btb_update;
        logic        bht_update;
        logic        lpht_update;
        logic [7:0]  lphr;
        logic [5:0]  lphr_index;
    } bpu_update_t;

    typedef enum logic {StClear, StRun} sched_state_e;

    // True when the record asks for any table to be trained.
    function automatic logic upd_trains(input bpu_update_t u);
        return u.btb_update | u.bht_update | u.lpht_update;
    endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Two-write / one-read circular queue of update records. Slot 0 writes at
// tail, slot 1 at tail+1; slot 1 is only ever enabled together with slot 0.
module bpu_upd_fifo
    import bpu_update_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          wr_en_i,
    input  bpu_update_t [1:0]   wr_data_i,
    input  logic                pop_i,
    output bpu_update_t         head_o,
    output logic [CntW-1:0]     count_o,
    output logic [CntW-1:0]     free_o
);

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
    logic [CntW-1:0] cnt_q, cnt_d;
    bpu_update_t     mem_q [FIFO_DEPTH];

    assign tail_p1 = tail_q + PtrW'(1);

    // Pointer / count next-state; pointers wrap naturally at power-of-two depth.
    always_comb begin
        head_d = head_q + PtrW'(pop_i);
        tail_d = tail_q + PtrW'(wr_en_i[0]) + PtrW'(wr_en_i[1]);
        cnt_d  = cnt_q + CntW'(wr_en_i[0]) + CntW'(wr_en_i[1]) - CntW'(pop_i);
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_i[0]) mem_q[tail_q]  <= wr_data_i[0];
        if (wr_en_i[1]) mem_q[tail_p1] <= wr_data_i[1];
    end

    assign head_o  = mem_q[head_q];
    assign count_o = cnt_q;
    // A same-cycle pop frees a slot for this cycle's pushes.
    assign free_o  = CntW'(FIFO_DEPTH) - cnt_q + CntW'(pop_i);

endmodule

// File: rtl/bpu_update_sched.sv
// Scheduler between two branch feedback lanes and the single BPU table
// write port: combinational redirect mux, clear walk after reset, and an
// in-order training queue drained one entry per granted cycle.
// Optional perf counters: define BPU_SCHED_PERF_EN.
module bpu_update_sched
    import bpu_update_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TBL_IDX_W  = BPU_TBL_IDX_W,
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           upd_valid_i,
    input  bpu_update_t [1:0]    upd_i,
    output logic                 redir_valid_o,
    output logic [29:0]          redir_target_o,
    output logic                 tbl_valid_o,
    output bpu_update_t          tbl_upd_o,
    input  logic                 tbl_ready_i,
    output logic                 tbl_clr_o,
    output logic [TBL_IDX_W-1:0] tbl_clr_idx_o,
    output logic                 busy_o
`ifdef BPU_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_redir_o,
    output logic [31:0]          perf_drop_o,
    output logic [31:0]          perf_stall_o
`endif
);

    sched_state_e         state_q;
    logic [TBL_IDX_W-1:0] clr_cnt_q;
    logic                 clr_q, busy_q;
    logic                 run;
    logic                 cand0, cand1, squash1, pop;
    logic [1:0]           n_cand, n_acc, wr_en;
    bpu_update_t [1:0]    wr_data;
    logic [CntW-1:0]      count, free;

    // Clear walk then run; outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            clr_q     <= 1'b1;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + TBL_IDX_W'(1);
                    if (clr_cnt_q == '1) begin
                        state_q <= StRun;
                        clr_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                end
            endcase
        end
    end

    assign run           = (state_q == StRun);
    assign tbl_clr_o     = clr_q;
    assign tbl_clr_idx_o = clr_cnt_q;
    assign busy_o        = busy_q;

    // Oldest flushing lane wins the redirect.
    always_comb begin
        redir_valid_o  = (upd_valid_i[0] & upd_i[0].flush) | (upd_valid_i[1] & upd_i[1].flush);
        redir_target_o = (upd_valid_i[0] & upd_i[0].flush) ? upd_i[0].br_target
                                                            : upd_i[1].br_target;
    end

    // Candidate selection, squash of the younger lane, and youngest-first drop.
    always_comb begin
        squash1 = upd_valid_i[0] & upd_i[0].flush;
        cand0   = upd_valid_i[0] & upd_trains(upd_i[0]);
        cand1   = upd_valid_i[1] & upd_trains(upd_i[1]) & ~squash1;
        n_cand  = 2'(cand0) + 2'(cand1);
        n_acc   = 2'd0;
        if (run) begin
            n_acc = (CntW'(n_cand) > free) ? free[1:0] : n_cand;
        end
        wr_en      = {n_acc == 2'd2, n_acc != 2'd0};
        wr_data[0] = cand0 ? upd_i[0] : upd_i[1];
        wr_data[1] = upd_i[1];
    end

    assign tbl_valid_o = run & (count != '0);
    assign pop         = tbl_valid_o & tbl_ready_i;

    bpu_upd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (pop),
        .head_o    (tbl_upd_o),
        .count_o   (count),
        .free_o    (free)
    );

`ifdef BPU_SCHED_PERF_EN
    logic [1:0]  n_drop;
    logic [32:0] redir_sum, drop_sum, stall_sum;
    logic [31:0] perf_redir_q, perf_drop_q, perf_stall_q;

    // Saturating event sums; bit 32 flags overflow.
    always_comb begin
        n_drop    = run ? (n_cand - n_acc) : 2'd0;
        redir_sum = {1'b0, perf_redir_q} + 33'(redir_valid_o);
        drop_sum  = {1'b0, perf_drop_q} + 33'(n_drop);
        stall_sum = {1'b0, perf_stall_q} + 33'(tbl_valid_o & ~tbl_ready_i);
    end

    // Performance counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redir_q <= '0;
            perf_drop_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_redir_q <= redir_sum[32] ? '1 : redir_sum[31:0];
            perf_drop_q  <= drop_sum[32]  ? '1 : drop_sum[31:0];
            perf_stall_q <= stall_sum[32] ? '1 : stall_sum[31:0];
        end
    end

    assign perf_redir_o = perf_redir_q;
    assign perf_drop_o  = perf_drop_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_bpu_update_sched.sv
// Scoreboard bench for bpu_update_sched with a 16-entry clear walk.
module tb_bpu_update_sched;
    import bpu_update_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        upd_valid;
    bpu_update_t [1:0] upd;
    logic              redir_valid;
    logic [29:0]       redir_target;
    logic              tbl_valid;
    bpu_update_t       tbl_upd;
    logic              tbl_ready;
    logic              tbl_clr;
    logic [3:0]        tbl_clr_idx;
    logic              busy;
`ifdef BPU_SCHED_PERF_EN
    logic [31:0]       perf_redir, perf_drop, perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q [$];

    always #5 clk = ~clk;

    bpu_update_sched #(
        .FIFO_DEPTH (4),
        .TBL_IDX_W  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .upd_valid_i    (upd_valid),
        .upd_i          (upd),
        .redir_valid_o  (redir_valid),
        .redir_target_o (redir_target),
        .tbl_valid_o    (tbl_valid),
        .tbl_upd_o      (tbl_upd),
        .tbl_ready_i    (tbl_ready),
        .tbl_clr_o      (tbl_clr),
        .tbl_clr_idx_o  (tbl_clr_idx),
        .busy_o         (busy)
`ifdef BPU_SCHED_PERF_EN
        ,
        .perf_redir_o   (perf_redir),
        .perf_drop_o    (perf_drop),
        .perf_stall_o   (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bpu_update_t mk(input logic [29:0] pc, input logic fl,
                                       input logic [29:0] tgt, input logic trn);
        bpu_update_t u;
        u            = '0;
        u.pc         = pc;
        u.flush      = fl;
        u.br_target  = tgt;
        u.btb_update = trn;
        u.br_type    = BR_TYPE_PC_RELATIVE;
        return u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [29:0] pc0, input logic [29:0] pc1);
        upd_valid = 2'b11;
        upd[0]    = mk(pc0, 1'b0, 30'h0, 1'b1);
        upd[1]    = mk(pc1, 1'b0, 30'h0, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !tbl_valid) break;
            tick();
        end
        chk(name, {62'(exp_q.size()), tbl_valid}, 64'h0);
    endtask

    // Monitor: every accepted table beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tbl_valid && tbl_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got pc %0h expected no beat", tbl_upd.pc);
            end else begin
                chk("beat_pc", tbl_upd.pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        upd_valid = 2'b00;
        upd       = '0;
        tbl_ready = 1'b1;
        #12;
        chk("rst_busy", busy, 1);
        chk("rst_clr", tbl_clr, 1);
        chk("rst_idx", tbl_clr_idx, 0);
        chk("rst_valid", tbl_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: clear walk 0..15; an update during CLEAR is discarded.
        for (int i = 0; i < 16; i++) begin
            chk("clr_busy", busy, 1);
            chk("clr_idx", tbl_clr_idx, 64'(i));
            if (i == 5) begin
                upd_valid = 2'b01;
                upd[0]    = mk(30'h55, 1'b0, 30'h0, 1'b1);
            end else begin
                upd_valid = 2'b00;
            end
            tick();
        end
        chk("run_busy", busy, 0);
        chk("run_clr", tbl_clr, 0);
        chk("run_valid_empty", tbl_valid, 0);

        // 2: dual update drains in order.
        drive2(30'h100, 30'h104);
        exp_q.push_back(30'h100);
        exp_q.push_back(30'h104);
        tick();
        upd_valid = 2'b00;
        wait_drain("t2_drain");

        // 3: lane0 flush wins redirect and squashes lane1.
        upd_valid = 2'b11;
        upd[0]    = mk(30'h200, 1'b1, 30'h2000, 1'b1);
        upd[1]    = mk(30'h204, 1'b1, 30'h3000, 1'b1);
        #1;
        chk("t3_redir_v", redir_valid, 1);
        chk("t3_redir_tgt", redir_target, 30'h2000);
        exp_q.push_back(30'h200);
        tick();
        upd[0] = mk(30'h208, 1'b0, 30'h0, 1'b0);
        upd[1] = mk(30'h20c, 1'b1, 30'h3000, 1'b0);
        #1;
        chk("t3_redir1_v", redir_valid, 1);
        chk("t3_redir1_tgt", redir_target, 30'h3000);
        tick();
        upd_valid = 2'b00;
        #1;
        chk("t3_redir_idle", redir_valid, 0);
        wait_drain("t3_drain");

        // 4: overflow with the port stalled; third cycle is dropped entirely.
        tbl_ready = 1'b0;
        drive2(30'h400, 30'h404);
        exp_q.push_back(30'h400);
        exp_q.push_back(30'h404);
        tick();
        drive2(30'h408, 30'h40c);
        exp_q.push_back(30'h408);
        exp_q.push_back(30'h40c);
        tick();
        drive2(30'h410, 30'h414);
        tick();
        upd_valid = 2'b00;
        chk("t4_valid", tbl_valid, 1);
        chk("t4_head", tbl_upd.pc, 30'h400);
        tick();
        tick();
        chk("t4_head_stable", tbl_upd.pc, 30'h400);
`ifdef BPU_SCHED_PERF_EN
        chk("t4_perf_drop", perf_drop, 2);
`endif
        tbl_ready = 1'b1;
        wait_drain("t4_drain");

        // 5: full queue with a pop admits only lane0; pointers wrap.
        tbl_ready = 1'b0;
        drive2(30'h500, 30'h504);
        exp_q.push_back(30'h500);
        exp_q.push_back(30'h504);
        tick();
        drive2(30'h508, 30'h50c);
        exp_q.push_back(30'h508);
        exp_q.push_back(30'h50c);
        tick();
        tbl_ready = 1'b1;
        drive2(30'h510, 30'h514);
        exp_q.push_back(30'h510);
        tick();
        tbl_ready = 1'b0;
        upd_valid = 2'b00;
        chk("t5_valid", tbl_valid, 1);
        chk("t5_head", tbl_upd.pc, 30'h504);
        tbl_ready = 1'b1;
        wait_drain("t5_drain");

        // 6: reset with 3 queued entries empties the queue and restarts the walk.
        tbl_ready = 1'b0;
        drive2(30'h600, 30'h604);
        tick();
        upd_valid = 2'b01;
        upd[0]    = mk(30'h608, 1'b0, 30'h0, 1'b1);
        tick();
        upd_valid = 2'b00;
        chk("t6_valid_pre", tbl_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", tbl_valid, 0);
        chk("t6_busy_rst", busy, 1);
        chk("t6_idx_rst", tbl_clr_idx, 0);
        upd_valid = 2'b01;
        upd[0]    = mk(30'h700, 1'b1, 30'h1234, 1'b1);
        #1;
        chk("t6_redir_v", redir_valid, 1);
        chk("t6_redir_tgt", redir_target, 30'h1234);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tbl_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t6_idx", tbl_clr_idx, 64'(i));
            if (i == 2) upd_valid = 2'b00;
            tick();
        end
        chk("t6_busy_done", busy, 0);
        chk("t6_valid_done", tbl_valid, 0);
        tick();
        tick();
        chk("t6_empty", {62'(exp_q.size()), tbl_valid}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
